mdu_unit: RTL and testbench

MDU_UNIT -- requirements
Module: mdu_unit

---
 rtl/mdu_unit.sv | 152 +++++++++++++++
 tb/tb_mdu_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_unit.sv
// Multiply/divide unit with a fixed-latency busy counter and architectural HI/LO registers.
// Optional macro MDU_DIV_ZERO_GUARD_EN: div/divu with B=0 is refused instead of running.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mf_out
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] count_q;
  logic [3:0]       op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;

  logic is_mul;
  logic is_div;
  logic div_zero_block;
  logic mt_hi_en;
  logic mt_lo_en;
  logic finish;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               a_neg;
  logic               b_neg;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        den;
  logic [31:0]        q_mag;
  logic [31:0]        r_mag;
  logic [31:0]        q_res;
  logic [31:0]        r_res;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;

  assign busy   = (count_q != '0);
  assign finish = (count_q == CNT_W'(1));

  always_comb begin
    is_mul   = (MDUop == OP_MULT) || (MDUop == OP_MULTU);
    is_div   = (MDUop == OP_DIV)  || (MDUop == OP_DIVU);
`ifdef MDU_DIV_ZERO_GUARD_EN
    div_zero_block = is_div && (B == 32'd0);
`else
    div_zero_block = 1'b0;
`endif
    start    = reset_n & req & (is_mul | is_div) & ~busy & ~div_zero_block;
    mt_hi_en = req & ~busy & (MDUop == OP_MTHI);
    mt_lo_en = req & ~busy & (MDUop == OP_MTLO);
  end

  always_comb begin
    case (MDUop)
      OP_MFHI: mf_out = HI;
      OP_MFLO: mf_out = LO;
      default: mf_out = 32'd0;
    endcase
  end

  // Signed divide is done on magnitudes so the 0x80000000 / -1 case falls out naturally.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    a_neg  = (op_q == OP_DIV) & a_q[31];
    b_neg  = (op_q == OP_DIV) & b_q[31];
    a_mag  = a_neg ? (~a_q + 32'd1) : a_q;
    b_mag  = b_neg ? (~b_q + 32'd1) : b_q;
    den    = (b_q == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / den;
    r_mag  = a_mag % den;
    q_res  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    r_res  = a_neg ? (~r_mag + 32'd1) : r_mag;

    res_hi = HI;
    res_lo = LO;
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV, OP_DIVU: begin
        if (b_q == 32'd0) begin
          res_hi = a_q;
          res_lo = 32'hFFFF_FFFF;
        end else begin
          res_hi = r_res;
          res_lo = q_res;
        end
      end
      default: begin
        res_hi = HI;
        res_lo = LO;
      end
    endcase
  end

  // Result lands on the edge the counter leaves 1, so it is visible the cycle busy drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      HI      <= 32'd0;
      LO      <= 32'd0;
    end else begin
      if (start) begin
        a_q     <= A;
        b_q     <= B;
        op_q    <= MDUop;
        count_q <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      end else if (busy) begin
        count_q <= count_q - CNT_W'(1);
      end

      if (finish) begin
        HI <= res_hi;
        LO <= res_lo;
      end else begin
        if (mt_hi_en) HI <= A;
        if (mt_lo_en) LO <= A;
      end
    end
  end

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed vector table, multi-cycle corner sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req = 1'b0;
  logic [3:0]  MDUop = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] mf_out;

  int errors = 0;
  int checks = 0;

  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  typedef struct {
    logic        rq;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .req    (req),
    .MDUop  (MDUop),
    .A      (A),
    .B      (B),
    .start  (start),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO),
    .mf_out (mf_out)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural effect of one presented operation, from plain arithmetic.
  task automatic compute_expected(input logic rq, input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output int cyc,
                                  output logic [31:0] eh, output logic [31:0] el);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    cyc = 0;
    eh  = model_hi;
    el  = model_lo;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    if (rq) begin
      case (op)
        4'd1: begin cyc = MC; sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
        4'd2: begin cyc = MC; up = ua * ub; eh = up[63:32]; el = up[31:0]; end
        4'd3, 4'd4: begin
          if (b == 32'd0) begin
`ifdef MDU_DIV_ZERO_GUARD_EN
            cyc = 0;
`else
            cyc = DC; eh = a; el = 32'hFFFF_FFFF;
`endif
          end else if (op == 4'd3) begin
            cyc = DC; sq = sa / sb; sr = sa % sb; eh = sr[31:0]; el = sq[31:0];
          end else begin
            cyc = DC; eh = 32'(ua % ub); el = 32'(ua / ub);
          end
        end
        4'd7: eh = a;
        4'd8: el = a;
        default: ;
      endcase
    end
  endtask

  // Presents one op for a cycle, then watches busy, holding mfhi to probe the pre-op value.
  task automatic apply_stimulus(input logic rq, input logic [3:0] op, input logic [31:0] a,
                                input logic [31:0] b, input int exp_cycles,
                                input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                                input string tag);
    int n;
    @(negedge clk);
    req = rq; MDUop = op; A = a; B = b;
    #1;
    check_output({tag, ".start"}, {31'd0, start}, {31'd0, exp_cycles != 0});
    @(negedge clk);
    req = 1'b0; MDUop = 4'd5; A = 32'd0; B = 32'd0;
    #1;
    n = 0;
    while (busy && n < 200) begin
      check_output({tag, ".hold_mf"}, mf_out, model_hi);
      check_output({tag, ".hold_lo"}, LO, model_lo);
      @(negedge clk);
      #1;
      n++;
    end
    check_output({tag, ".cycles"}, 32'(n), 32'(exp_cycles));
    check_output({tag, ".hi"}, HI, exp_hi);
    check_output({tag, ".lo"}, LO, exp_lo);
    check_output({tag, ".mf"}, mf_out, exp_hi);
    model_hi = exp_hi;
    model_lo = exp_lo;
    MDUop = 4'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; req = 1'b1; MDUop = 4'd1; A = 32'd3; B = 32'd4;
    #1;
    check_output("reset.start", {31'd0, start}, 32'd0);
    repeat (2) @(negedge clk);
    check_output("reset.busy", {31'd0, busy}, 32'd0);
    check_output("reset.hi", HI, 32'd0);
    check_output("reset.lo", LO, 32'd0);
    MDUop = 4'd6;
    #1;
    check_output("reset.mf", mf_out, 32'd0);
    req = 1'b0; MDUop = 4'd0; A = 32'd0; B = 32'd0;
    reset_n = 1'b1;
    model_hi = 32'd0;
    model_lo = 32'd0;
  endtask

  initial begin
    int n;
    int cyc;
    logic [31:0] eh, el, ra, rb;
    logic [3:0] rop;
    logic rrq;

    $display("[TB] mdu_unit bench starting");
    do_reset();

    vecs.push_back('{1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, MC, 32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{1'b1, 4'd2, 32'hFFFF_FFFE, 32'd3, MC, 32'h0000_0002, 32'hFFFF_FFFA});
    vecs.push_back('{1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, DC, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{1'b1, 4'd4, 32'd7, 32'd2, DC, 32'd1, 32'd3});
    vecs.push_back('{1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 32'd0, 32'h8000_0000});
    vecs.push_back('{1'b1, 4'd3, 32'd7, 32'hFFFF_FFFE, DC, 32'd1, 32'hFFFF_FFFD});
    vecs.push_back('{1'b1, 4'd4, 32'hFFFF_FFFF, 32'd16, DC, 32'd15, 32'h0FFF_FFFF});
    vecs.push_back('{1'b1, 4'd7, 32'h1234_5678, 32'd0, 0, 32'h1234_5678, 32'h0FFF_FFFF});
    vecs.push_back('{1'b1, 4'd8, 32'h9ABC_DEF0, 32'd0, 0, 32'h1234_5678, 32'h9ABC_DEF0});
    vecs.push_back('{1'b1, 4'd9, 32'd1, 32'd1, 0, 32'h1234_5678, 32'h9ABC_DEF0});
`ifdef MDU_DIV_ZERO_GUARD_EN
    vecs.push_back('{1'b1, 4'd4, 32'd5, 32'd0, 0, 32'h1234_5678, 32'h9ABC_DEF0});
`else
    vecs.push_back('{1'b1, 4'd4, 32'd5, 32'd0, DC, 32'd5, 32'hFFFF_FFFF});
`endif
    vecs.push_back('{1'b1, 4'd1, 32'h8000_0000, 32'h8000_0000, MC, 32'h4000_0000, 32'd0});
    vecs.push_back('{1'b1, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000, MC, 32'hC000_0000, 32'h8000_0000});
`ifdef MDU_DIV_ZERO_GUARD_EN
    vecs.push_back('{1'b1, 4'd3, 32'hFFFF_FFF9, 32'd0, 0, 32'hC000_0000, 32'h8000_0000});
`else
    vecs.push_back('{1'b1, 4'd3, 32'hFFFF_FFF9, 32'd0, DC, 32'hFFFF_FFF9, 32'hFFFF_FFFF});
`endif
    vecs.push_back('{1'b0, 4'd1, 32'd9, 32'd9, 0, vecs[13].hi, vecs[13].lo});

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i].rq, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cycles,
                     vecs[i].hi, vecs[i].lo, $sformatf("vec%0d", i));

    @(negedge clk);
    MDUop = 4'd6; #1; check_output("mf.lo", mf_out, model_lo);
    MDUop = 4'd7; #1; check_output("mf.other", mf_out, 32'd0);
    MDUop = 4'd0;

    // Abort: reset asserted during the third busy cycle of a mult.
    apply_stimulus(1'b1, 4'd7, 32'h1111_1111, 32'd0, 0, 32'h1111_1111, model_lo, "abort.mthi");
    apply_stimulus(1'b1, 4'd8, 32'h2222_2222, 32'd0, 0, 32'h1111_1111, 32'h2222_2222, "abort.mtlo");
    @(negedge clk);
    req = 1'b1; MDUop = 4'd1; A = 32'd7; B = 32'd9;
    #1;
    check_output("abort.start", {31'd0, start}, 32'd1);
    @(negedge clk);
    req = 1'b0; MDUop = 4'd0;
    #1;
    check_output("abort.busy1", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check_output("abort.busy", {31'd0, busy}, 32'd0);
    check_output("abort.hi", HI, 32'd0);
    check_output("abort.lo", LO, 32'd0);
    repeat (12) @(negedge clk);
    check_output("abort.late_hi", HI, 32'd0);
    check_output("abort.late_lo", LO, 32'd0);
    check_output("abort.late_busy", {31'd0, busy}, 32'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;

    // mtlo held during a divu: ignored while busy, then accepted once busy drops.
    @(negedge clk);
    req = 1'b1; MDUop = 4'd4; A = 32'd7; B = 32'd2;
    #1;
    check_output("mtlo_busy.start", {31'd0, start}, 32'd1);
    @(negedge clk);
    MDUop = 4'd8; A = 32'hDEAD_BEEF; B = 32'd0;
    #1;
    n = 0;
    while (busy && n < 200) begin
      check_output("mtlo_busy.hold", LO, model_lo);
      @(negedge clk);
      #1;
      n++;
    end
    check_output("mtlo_busy.cycles", 32'(n), 32'(DC));
    check_output("mtlo_busy.lo", LO, 32'd3);
    check_output("mtlo_busy.hi", HI, 32'd1);
    @(negedge clk);
    req = 1'b0; MDUop = 4'd0;
    check_output("mtlo_busy.late_lo", LO, 32'hDEAD_BEEF);
    check_output("mtlo_busy.late_busy", {31'd0, busy}, 32'd0);
    model_hi = 32'd1;
    model_lo = 32'hDEAD_BEEF;

    // Back-to-back: stalled mult re-presented, second op starts the cycle busy drops.
    @(negedge clk);
    req = 1'b1; MDUop = 4'd1; A = 32'hFFFF_FFFE; B = 32'd3;
    #1;
    check_output("b2b.start1", {31'd0, start}, 32'd1);
    @(negedge clk);
    #1;
    n = 0;
    while (busy && n < 200) begin
      check_output("b2b.stall", {31'd0, start}, 32'd0);
      @(negedge clk);
      #1;
      n++;
    end
    check_output("b2b.cycles1", 32'(n), 32'(MC));
    check_output("b2b.hi1", HI, 32'hFFFF_FFFF);
    check_output("b2b.lo1", LO, 32'hFFFF_FFFA);
    A = 32'd5; B = 32'd6;
    #1;
    check_output("b2b.start2", {31'd0, start}, 32'd1);
    @(negedge clk);
    req = 1'b0; MDUop = 4'd0;
    #1;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_output("b2b.cycles2", 32'(n), 32'(MC));
    check_output("b2b.hi2", HI, 32'd0);
    check_output("b2b.lo2", LO, 32'd30);
    model_hi = 32'd0;
    model_lo = 32'd30;

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      rrq = ($urandom_range(0, 9) != 0);
      rop = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 8));
      case ($urandom_range(0, 5))
        0: ra = 32'h8000_0000;
        1: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 6))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'd1;
        3: rb = $urandom_range(2, 100);
        default: rb = $urandom;
      endcase
      compute_expected(rrq, rop, ra, rb, cyc, eh, el);
      apply_stimulus(rrq, rop, ra, rb, cyc, eh, el, $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
